// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                     |
// | Brief    : Byte FIFO feeding a baud-rate serializer (8N1, or 8E1 when       |
// |            UART_TX_PARITY_EN is defined).                                   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DIVISOR    = 217,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dataTX,
  input  logic       WR_TX,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int                c_ADDR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0]  c_BIT_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [c_ADDR_W:0] c_DEPTH    = (c_ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic [c_ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [c_ADDR_W:0]   count_q, count_d;
  logic                full_q, empty_q, busy_q, ovf_q;
  logic [7:0]          mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic w_wr_acc, w_bit_end, w_pop;

  assign w_wr_acc  = WR_TX && !full_q;
  assign w_bit_end = (cnt_q == c_BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = w_bit_end ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    w_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty_q) begin
          w_pop   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit so queued frames leave no idle gap.
        if (w_bit_end) begin
          if (!empty_q) begin
            w_pop   = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_pop) begin
      shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end

    // The line level is registered from the next state so tx never glitches.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    rd_ptr_d = w_pop    ? rd_ptr_q + c_ADDR_W'(1) : rd_ptr_q;
    wr_ptr_d = w_wr_acc ? wr_ptr_q + c_ADDR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    if (w_wr_acc && !w_pop)      count_d = count_q + (c_ADDR_W + 1)'(1);
    else if (!w_wr_acc && w_pop) count_d = count_q - (c_ADDR_W + 1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == c_DEPTH);
      empty_q  <= (count_d == '0);
      busy_q   <= (state_d != S_IDLE) || (count_d != '0);
      ovf_q    <= WR_TX && full_q;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Storage needs no reset: pointers and count alone define what is queued.
  always_ff @(posedge clk) begin
    if (w_wr_acc) mem_q[wr_ptr_q] <= dataTX;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_fifo                                                  |
// | Brief    : Self-checking bench for uart_tx_fifo with a frame-timing model   |
// |            and an independent line decoder.                                 |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dataTX;
  logic       WR_TX;
  logic       tx, busy, full, empty, overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DIVISOR(DIV), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dataTX(dataTX), .WR_TX(WR_TX),
    .tx(tx), .busy(busy), .full(full), .empty(empty), .overflow(overflow)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: FIFO contents, cycles left in the frame on the line, its byte.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  int         m_t;
  logic [7:0] m_cur;
  logic       m_ovf;
  int         n_frames;
  int         n_ovf_seen;
  // Line decoder state.
  logic       d_active;
  int         d_k;
  logic [7:0] d_byte;
  logic       prev_tx;

  function automatic logic exp_tx();
    int k, b;
    if (m_t == 0) return 1'b1;
    k = FRAME - m_t;
    b = k / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    if (b == 9 && NBITS == 11) return ^m_cur;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_t      = 0;
    m_cur    = 8'h00;
    m_ovf    = 1'b0;
    d_active = 1'b0;
    d_k      = 0;
    prev_tx  = 1'b1;
  endtask

  task automatic decode();
    int b;
    if (!d_active && prev_tx === 1'b1 && tx === 1'b0) begin
      d_active = 1'b1;
      d_k      = 0;
      d_byte   = 8'h00;
    end
    if (d_active) begin
      if (d_k % DIV == DIV / 2) begin
        b = d_k / DIV;
        if (b == 0) check("start_bit", tx, 0);
        else if (b <= 8) d_byte[b-1] = tx;
        else if (b == NBITS - 1) begin
          check("stop_bit", tx, 1);
          if (sb.size() == 0) check("unexpected_frame", 1, 0);
          else check("frame_byte", d_byte, sb.pop_front());
          n_frames++;
          d_active = 1'b0;
        end else check("parity_bit", tx, ^d_byte);
      end
      d_k++;
    end
    prev_tx = tx;
  endtask

  task automatic step(input logic wr, input logic [7:0] d);
    logic pop, acc;
    WR_TX  = wr;
    dataTX = d;
    @(posedge clk);
    pop   = (mq.size() > 0) && (m_t <= 1);
    acc   = wr && (mq.size() < DEPTH);
    m_ovf = wr && (mq.size() == DEPTH);
    if (m_t > 0) m_t--;
    if (pop) begin
      m_cur = mq.pop_front();
      m_t   = FRAME;
    end
    if (acc) begin
      mq.push_back(d);
      sb.push_back(d);
    end
    #1;
    check("tx", tx, exp_tx());
    check("busy", busy, (m_t > 0) || (mq.size() > 0));
    check("full", full, mq.size() == DEPTH);
    check("empty", empty, mq.size() == 0);
    check("overflow", overflow, m_ovf);
    if (overflow === 1'b1) n_ovf_seen++;
    decode();
    WR_TX = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 2000; i++) begin
      if (m_t == 0 && mq.size() == 0 && !d_active) break;
      step(1'b0, 8'h00);
    end
    check("drain_done", (m_t == 0 && mq.size() == 0) ? 1 : 0, 1);
    repeat (3) step(1'b0, 8'h00);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, lat, t_fall;
    n_frames   = 0;
    n_ovf_seen = 0;
    rst    = 1'b1;
    WR_TX  = 1'b0;
    dataTX = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;

    repeat (50) step(1'b0, 8'h00);

    // Single byte: tx falls one edge after the write, busy drops a frame later.
    f0 = n_frames; lat = -1; t_fall = -1;
    step(1'b1, 8'h41);
    for (int i = 1; i <= 200; i++) begin
      step(1'b0, 8'h00);
      if (t_fall < 0 && tx === 1'b0) t_fall = i;
      if (busy === 1'b0) begin lat = i; break; end
    end
    check("tx_fall_cycle", t_fall, 1);
    check("busy_fall_cycle", lat, FRAME + 1);
    drain();
    check("frames_single", n_frames - f0, 1);

    // Four consecutive writes into an idle block.
    f0 = n_frames;
    step(1'b1, 8'h55); step(1'b1, 8'hAA); step(1'b1, 8'h0F); step(1'b1, 8'hF0);
    drain();
    check("frames_four", n_frames - f0, 4);

    // Fill behind a running frame; fifth write coincides with the stop-end pop.
    f0 = n_frames; n_ovf_seen = 0;
    step(1'b1, 8'hA5);
    repeat (FRAME - 4) step(1'b0, 8'h00);
    step(1'b1, 8'h11); step(1'b1, 8'h22); step(1'b1, 8'h33); step(1'b1, 8'h44);
    check("full_after_4", full, 1);
    step(1'b1, 8'h99);
    check("ovf_on_pop_cycle", overflow, 1);
    drain();
    check("ovf_pulses", n_ovf_seen, 1);
    check("frames_overflow", n_frames - f0, 5);

    // Asynchronous reset during data bit 3 of 0x3C.
    step(1'b1, 8'h3C);
    repeat (2 + 4 * DIV + 2) step(1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_empty", empty, 1);
    check("async_rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) step(1'b0, 8'h00);
    f0 = n_frames;
    step(1'b1, 8'h7E);
    drain();
    check("frames_after_rst", n_frames - f0, 1);

`ifdef UART_TX_PARITY_EN
    step(1'b1, 8'h07);
    repeat (9 * DIV + 3) step(1'b0, 8'h00);
    check("parity_07", tx, 1);
    drain();
    step(1'b1, 8'h03);
    repeat (9 * DIV + 3) step(1'b0, 8'h00);
    check("parity_03", tx, 0);
    drain();
`endif

    // Randomized traffic with occasional bursts.
    f0 = n_frames;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 8) step(1'b1, 8'($urandom));
      else step(1'b0, 8'h00);
    end
    drain();
    check("sb_leftover", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
